// File: rtl/serial_sub8_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the default operand width.
package serial_sub8_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder; the serial subtractor reuses this single cell on every
// bit position.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock
// through a single full-adder cell, with valid/ready handshakes on both sides.
module serial_sub8
    import serial_sub8_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(WIDTH - 1);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_carry;
    cnt_t             r_cnt;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_res_next;

    serial_fa_cell u_cell (
        .x  (r_a_sh[0]),
        .y  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_res_next = {w_s, r_res_sh[WIDTH-1:1]};

    // NOTE: every register here uses <= so all updates within an edge see the
    // pre-edge values; blocking assignments would let the shift chain race.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res_sh    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // a - b = a + ~b + 1: the +1 enters as the initial carry
                        r_a_sh     <= a;
                        r_b_sh     <= ~b;
                        r_carry    <= 1'b1;
                        r_cnt      <= '0;
                        r_res_sh   <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_res_next;
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + cnt_t'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_diff      <= w_res_next;
                        r_borrow    <= ~w_co;
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_sub8.sv
// Self-checking bench for serial_sub8: directed cases, backpressure, protocol,
// mid-operation reset, and a randomized run against an arithmetic model.
module tb_serial_sub8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow_out;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    serial_sub8 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic modulo 256.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] d;
        d = 8'((int'(x) - int'(y) + 256) % 256);
        return {(x < y), d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation starting in IDLE and reports what was observed.
    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input int stall,
                          output int lat, output logic rdy0, output logic busy_run,
                          output logic [8:0] got, output logic stable,
                          output logic rdy_after, output logic ov_after);
        rdy0      = in_ready;
        in_valid  = 1'b1;
        a         = ai;
        b         = bi;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        busy_run = busy;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        got    = {borrow_out, diff};
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            if ({borrow_out, diff} !== got || out_valid !== 1'b1) stable = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rdy_after = in_ready;
        ov_after  = out_valid;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (diff !== 8'h00)     begin n_err++; $display("FAIL reset_diff got=%h exp=00", diff); end
        n_cmp++; if (borrow_out !== 1'b0) begin n_err++; $display("FAIL reset_borrow got=%b exp=0", borrow_out); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [7:0] ta [4] = '{8'd100, 8'd37, 8'h00, 8'hFF};
        logic [7:0] tb [4] = '{8'd37, 8'd100, 8'h01, 8'hFF};
        logic [8:0] ex [4] = '{9'h03F, 9'h1C1, 9'h1FF, 9'h000};
        int lat; logic r0, br, st, ra, oa; logic [8:0] got;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], 0, lat, r0, br, got, st, ra, oa);
            n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL dir%0d_in_ready got=%b exp=1", i, r0); end
            n_cmp++; if (br !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy got=%b exp=1", i, br); end
            n_cmp++; if (lat != 8)    begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=8", i, lat); end
            n_cmp++; if (got !== ex[i]) begin n_err++; $display("FAIL dir%0d_result got=%h exp=%h", i, got, ex[i]); end
            n_cmp++; if (ra !== 1'b1 || oa !== 1'b0) begin n_err++; $display("FAIL dir%0d_after_hs in_ready=%b out_valid=%b exp 1/0", i, ra, oa); end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic r0, br, st, ra, oa; logic [8:0] got;
        run_op(8'h80, 8'h01, 5, lat, r0, br, got, st, ra, oa);
        n_cmp++; if (got !== 9'h07F) begin n_err++; $display("FAIL bp_result got=%h exp=07F", got); end
        n_cmp++; if (st !== 1'b1)    begin n_err++; $display("FAIL bp_stable got=%b exp=1", st); end
        n_cmp++; if (oa !== 1'b0 || ra !== 1'b1) begin n_err++; $display("FAIL bp_single_hs out_valid=%b in_ready=%b exp 0/1", oa, ra); end
    endtask

    task automatic test_protocol();
        int lat;
        logic ignored;
        in_valid = 1'b1; a = 8'h10; b = 8'h05; out_ready = 1'b0;
        tick();
        a = 8'hAA; b = 8'h55;
        ignored = 1'b1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) ignored = 1'b0;
            tick();
            lat++;
        end
        n_cmp++; if (ignored !== 1'b1) begin n_err++; $display("FAIL proto_busy_ignore got=%b exp=1", ignored); end
        n_cmp++; if ({borrow_out, diff} !== 9'h00B) begin n_err++; $display("FAIL proto_result got=%h exp=00B", {borrow_out, diff}); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // in_valid stayed high across the handshake edge; it must not be taken there
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL proto_no_accept_on_hs in_ready=%b busy=%b exp 1/0", in_ready, busy); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL proto_second_accept busy got=%b exp=1", busy); end
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        n_cmp++; if ({borrow_out, diff} !== model(8'hAA, 8'h55)) begin n_err++; $display("FAIL proto_second_result got=%h exp=%h", {borrow_out, diff}, model(8'hAA, 8'h55)); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        int lat; logic r0, br, st, ra, oa; logic [8:0] got;
        in_valid = 1'b1; a = 8'hF0; b = 8'h0F;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || diff !== 8'h00)
            begin n_err++; $display("FAIL midrst_state in_ready=%b out_valid=%b busy=%b diff=%h exp 1/0/0/00", in_ready, out_valid, busy, diff); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_pulse got=%b exp=0", out_valid); end
        run_op(8'd3, 8'd5, 0, lat, r0, br, got, st, ra, oa);
        n_cmp++; if (got !== 9'h1FE) begin n_err++; $display("FAIL midrst_after got=%h exp=1FE", got); end
    endtask

    task automatic test_back_to_back();
        int lat; logic r0, br, st, ra, oa; logic [8:0] got, exp_v;
        logic [7:0] ra_v, rb_v;
        for (int n = 0; n < 1000; n++) begin
            ra_v = 8'($urandom);
            rb_v = 8'($urandom);
            if (n % 10 == 0) rb_v = ra_v;
            exp_v = model(ra_v, rb_v);
            run_op(ra_v, rb_v, int'($urandom_range(0, 3)), lat, r0, br, got, st, ra, oa);
            n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL rand%0d a=%h b=%h got=%h exp=%h", n, ra_v, rb_v, got, exp_v); end
            n_cmp++; if (lat != 8 || r0 !== 1'b1 || st !== 1'b1) begin n_err++; $display("FAIL rand%0d_proto lat=%0d in_ready=%b stable=%b exp 8/1/1", n, lat, r0, st); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_protocol();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
